conv_engine: RTL and testbench

Parametrised 2-D valid convolution engine: the next generation of the fixed 4x4-by-3x3 computation module. It stores an N x N data tile and a K x K kernel, then computes the (N-K+1) x (N-K+1) output with either one time-multiplexed MAC or one MAC per output column. It sits behind the same controller that drives load/start strobes and reads results after a done pulse.

---
 rtl/conv_engine.sv | 201 ++++++++++++++++++++
 tb/tb_conv_engine.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_engine.sv
// conv_engine: N x N by K x K valid 2-D convolution with one time-multiplexed MAC (mode 0)
// or one MAC per output column (mode 1). Build option CONV_SAT_EN saturates outputs instead of wrapping.

module conv_engine #(
  parameter int DW = 8,
  parameter int N  = 4,
  parameter int K  = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [N*N*DW-1:0]                 a_flat,
  input  logic [K*K*DW-1:0]                 b_flat,
  input  logic                              start,
  input  logic                              mode,
  output logic                              busy,
  output logic                              done,
  output logic [(N-K+1)*(N-K+1)*DW-1:0]     c_flat
);

  localparam int M  = N - K + 1;
  localparam int AW = 2*DW + $clog2(K*K);
  localparam int CW = $clog2(N + 1);

  if (K < 1 || N < K) begin : g_param_check
    $error("conv_engine: requires K >= 1 and N >= K");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N*N*DW-1:0] a_q, a_d;
  logic [K*K*DW-1:0] b_q, b_d;
  logic [M*M*DW-1:0] res_q, res_d;
  logic              mode_q, mode_d;
  logic [CW-1:0]     tj_q, tj_d, ti_q, ti_d;
  logic [CW-1:0]     col_q, col_d, row_q, row_d;
  logic [CW-1:0]     wr_row_q, wr_row_d, wr_col_q, wr_col_d;
  logic              wr_q, wr_d, fin_q, fin_d;
  logic [AW-1:0]     acc_q [M];
  logic [AW-1:0]     acc_d [M];
  logic [AW-1:0]     prod  [M];
  logic              start_ok, load_ok;

  function automatic logic [DW-1:0] a_elem(input logic [N*N*DW-1:0] v, input int rr, input int cc);
    logic [DW-1:0] e;
    e = '0;
    for (int x = 0; x < N; x++)
      for (int y = 0; y < N; y++)
        if (x == rr && y == cc) e = v[(x*N+y)*DW +: DW];
    return e;
  endfunction

  function automatic logic [DW-1:0] b_elem(input logic [K*K*DW-1:0] v, input int ii, input int jj);
    logic [DW-1:0] e;
    e = '0;
    for (int x = 0; x < K; x++)
      for (int y = 0; y < K; y++)
        if (x == ii && y == jj) e = v[(x*K+y)*DW +: DW];
    return e;
  endfunction

  function automatic logic [DW-1:0] reduce(input logic [AW-1:0] s);
`ifdef CONV_SAT_EN
    return (|s[AW-1:DW]) ? {DW{1'b1}} : s[DW-1:0];
`else
    return DW'(s);
`endif
  endfunction

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (fin_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign c_flat = res_q;

  // In mode 0 only lane 0 is used and the column comes from col_q.
  always_comb begin
    for (int l = 0; l < M; l++) begin
      prod[l] = AW'(a_elem(a_q, int'(row_q) + int'(ti_q),
                           (mode_q ? l : int'(col_q)) + int'(tj_q)))
              * AW'(b_elem(b_q, int'(ti_q), int'(tj_q)));
    end
  end

  always_comb begin
    start_ok = (state_q == S_IDLE) && start;
    load_ok  = (state_q == S_IDLE) && load;
    a_d      = load_ok ? a_flat : a_q;
    b_d      = load_ok ? b_flat : b_q;
    mode_d   = start_ok ? mode : mode_q;
    tj_d     = tj_q;
    ti_d     = ti_q;
    col_d    = col_q;
    row_d    = row_q;
    wr_row_d = wr_row_q;
    wr_col_d = wr_col_q;
    wr_d     = 1'b0;
    fin_d    = 1'b0;
    res_d    = res_q;
    for (int l = 0; l < M; l++) acc_d[l] = acc_q[l];

    if (start_ok) begin
      tj_d  = '0;
      ti_d  = '0;
      col_d = '0;
      row_d = '0;
      for (int l = 0; l < M; l++) acc_d[l] = '0;
    end else if (state_q == S_RUN && !fin_q) begin
      // The first tap replaces the accumulator so the previous sum can be written this same cycle.
      for (int l = 0; l < M; l++)
        if (mode_q || l == 0)
          acc_d[l] = ((tj_q == '0 && ti_q == '0) ? '0 : acc_q[l]) + prod[l];

      if (tj_q != CW'(K-1)) begin
        tj_d = tj_q + CW'(1);
      end else begin
        tj_d = '0;
        if (ti_q != CW'(K-1)) begin
          ti_d = ti_q + CW'(1);
        end else begin
          ti_d     = '0;
          wr_d     = 1'b1;
          wr_row_d = row_q;
          wr_col_d = col_q;
          if (!mode_q && col_q != CW'(M-1)) begin
            col_d = col_q + CW'(1);
          end else begin
            col_d = '0;
            if (row_q == CW'(M-1)) fin_d = 1'b1;
            else                   row_d = row_q + CW'(1);
          end
        end
      end
    end

    if (wr_q) begin
      for (int rr = 0; rr < M; rr++)
        for (int cc = 0; cc < M; cc++)
          if (int'(wr_row_q) == rr && (mode_q || int'(wr_col_q) == cc))
            res_d[(rr*M+cc)*DW +: DW] = reduce(mode_q ? acc_q[cc] : acc_q[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      mode_q   <= 1'b0;
      tj_q     <= '0;
      ti_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      wr_row_q <= '0;
      wr_col_q <= '0;
      wr_q     <= 1'b0;
      fin_q    <= 1'b0;
      for (int l = 0; l < M; l++) acc_q[l] <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      mode_q   <= mode_d;
      tj_q     <= tj_d;
      ti_q     <= ti_d;
      col_q    <= col_d;
      row_q    <= row_d;
      wr_row_q <= wr_row_d;
      wr_col_q <= wr_col_d;
      wr_q     <= wr_d;
      fin_q    <= fin_d;
      for (int l = 0; l < M; l++) acc_q[l] <= acc_d[l];
    end
  end

endmodule

// File: tb/tb_conv_engine.sv
// Self-checking bench for conv_engine: default 4x4/3x3 instance plus a 5x5/2x2 instance.
// Expected outputs come from a plain-arithmetic convolution model honouring CONV_SAT_EN.

module tb_conv_engine;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int K  = 3;
  localparam int M  = N - K + 1;
  localparam int N5 = 5;
  localparam int K5 = 2;
  localparam int M5 = N5 - K5 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, load, start, mode, busy, done;
  logic [N*N*DW-1:0]    a_flat;
  logic [K*K*DW-1:0]    b_flat;
  logic [M*M*DW-1:0]    c_flat;

  logic                 load5, start5, mode5, busy5, done5;
  logic [N5*N5*DW-1:0]  a5;
  logic [K5*K5*DW-1:0]  b5;
  logic [M5*M5*DW-1:0]  c5;

  conv_engine #(.DW(DW), .N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .load(load), .a_flat(a_flat), .b_flat(b_flat),
    .start(start), .mode(mode), .busy(busy), .done(done), .c_flat(c_flat)
  );

  conv_engine #(.DW(DW), .N(N5), .K(K5)) dut5 (
    .clk(clk), .rst(rst), .load(load5), .a_flat(a5), .b_flat(b5),
    .start(start5), .mode(mode5), .busy(busy5), .done(done5), .c_flat(c5)
  );

  int tests = 0;
  int fails = 0;
  int am [N][N];
  int bm [K][K];

  function automatic logic [M*M*DW-1:0] model_c();
    logic [M*M*DW-1:0] v;
    longint s;
    v = '0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < M; c++) begin
        s = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            s += longint'(am[r+i][c+j]) * longint'(bm[i][j]);
`ifdef CONV_SAT_EN
        if (s > 255) s = 255;
`endif
        v[(r*M+c)*DW +: DW] = s[DW-1:0];
      end
    return v;
  endfunction

  task automatic pack_and_load();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) a_flat[(r*N+c)*DW +: DW] = DW'(am[r][c]);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) b_flat[(i*K+j)*DW +: DW] = DW'(bm[i][j]);
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic randomize_tile(input int maxv);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) am[r][c] = int'($urandom_range(0, maxv));
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) bm[i][j] = int'($urandom_range(0, maxv));
  endtask

  task automatic spec_tile();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) am[r][c] = c + 1;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++) bm[i][j] = i + 1;
  endtask

  task automatic check_c(input string name);
    logic [M*M*DW-1:0] e;
    e = model_c();
    tests++;
    if (c_flat !== e) begin
      fails++;
      $display("FAIL %s c_flat: got %h expected %h", name, c_flat, e);
    end
  endtask

  // One run: start pulse, count edges to done, then check the pulse is one cycle wide.
  task automatic run(input logic m, input int exp_lat, input string name);
    int cnt;
    bit seen;
    @(negedge clk);
    start = 1'b1; mode = m;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
      seen = (done === 1'b1);
    end
    tests++;
    if (!seen || cnt != exp_lat) begin
      fails++;
      $display("FAIL %s latency: got %0d cycles (done seen=%0b) expected %0d", name, cnt, seen, exp_lat);
    end
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s busy_at_done: got %b expected 1", name, busy);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; start = 1'b0; mode = 1'b0; a_flat = '0; b_flat = '0;
    load5 = 1'b0; start5 = 1'b0; mode5 = 1'b0; a5 = '0; b5 = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || c_flat !== '0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b c=%h expected 0 0 0", busy, done, c_flat);
    end
    tests++;
    if (busy5 !== 1'b0 || done5 !== 1'b0 || c5 !== '0) begin
      fails++;
      $display("FAIL reset_state5: got busy=%b done=%b c=%h expected 0 0 0", busy5, done5, c5);
    end
    rst = 1'b0;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) am[r][c] = 0;
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) bm[i][j] = 0;
    run(1'b0, 37, "reset_idle_run");
    check_c("reset_idle_run");
  endtask

  task automatic test_mode0();
    logic [M*M*DW-1:0] k;
    k = {8'd54, 8'd36, 8'd54, 8'd36};
    spec_tile();
    pack_and_load();
    run(1'b0, 37, "mode0");
    check_c("mode0");
    tests++;
    if (c_flat !== k) begin
      fails++;
      $display("FAIL mode0_const: got %h expected %h", c_flat, k);
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] ev;
    bit ok;
`ifdef CONV_SAT_EN
    ev = 8'd255;
`else
    ev = 8'd9;
`endif
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) am[r][c] = 255;
    for (int i = 0; i < K; i++) for (int j = 0; j < K; j++) bm[i][j] = 255;
    pack_and_load();
    run(1'b0, 37, "overflow");
    check_c("overflow");
    ok = 1'b1;
    for (int e = 0; e < M*M; e++) if (c_flat[e*DW +: DW] !== ev) ok = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL overflow_const: got %h expected every element %0d", c_flat, ev);
    end
  endtask

  task automatic test_mode1();
    logic [M*M*DW-1:0] k;
    k = {8'd54, 8'd36, 8'd54, 8'd36};
    spec_tile();
    pack_and_load();
    run(1'b1, 19, "mode1");
    check_c("mode1");
    tests++;
    if (c_flat !== k) begin
      fails++;
      $display("FAIL mode1_const: got %h expected %h", c_flat, k);
    end
  endtask

  task automatic test_random();
    logic m;
    for (int it = 0; it < 8; it++) begin
      randomize_tile((it % 2 == 0) ? 255 : 15);
      m = 1'($urandom_range(0, 1));
      pack_and_load();
      run(m, m ? (M*K*K + 1) : (M*M*K*K + 1), "random");
      check_c("random");
    end
  endtask

  task automatic test_busy_ignore();
    int cnt;
    bit seen;
    spec_tile();
    pack_and_load();
    @(negedge clk);
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 5) begin
        start = 1'b1; load = 1'b1; mode = 1'b0;
        a_flat = {$urandom, $urandom, $urandom, $urandom};
        b_flat = {$urandom, $urandom, $urandom};
      end
      if (cnt == 6) begin
        start = 1'b0; load = 1'b0;
      end
      seen = (done === 1'b1);
    end
    tests++;
    if (!seen || cnt != 19) begin
      fails++;
      $display("FAIL busy_ignore latency: got %0d (seen=%0b) expected 19", cnt, seen);
    end
    check_c("busy_ignore");
    @(posedge clk); #1;
    run(1'b0, 37, "busy_ignore_rerun");
    check_c("busy_ignore_rerun");
  endtask

  task automatic test_back_to_back();
    randomize_tile(255);
    pack_and_load();
    run(1'b1, 19, "b2b_first");
    check_c("b2b_first");
    run(1'b0, 37, "b2b_second");
    check_c("b2b_second");
  endtask

  task automatic test_start_held();
    int cnt;
    bit seen;
    randomize_tile(255);
    pack_and_load();
    @(negedge clk);
    start = 1'b1; mode = 1'b1;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
      seen = (done === 1'b1);
    end
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
      seen = (done === 1'b1);
    end
    start = 1'b0;
    tests++;
    if (!seen || cnt != 21) begin
      fails++;
      $display("FAIL start_held interval: got %0d (seen=%0b) expected 21", cnt, seen);
    end
    check_c("start_held");
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL start_held idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_midrun();
    int cnt;
    bit early;
    randomize_tile(255);
    pack_and_load();
    @(negedge clk);
    start = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    early = 1'b0;
    for (cnt = 0; cnt < 10; cnt++) begin
      @(posedge clk); #1;
      if (done === 1'b1) early = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || c_flat !== '0) begin
      fails++;
      $display("FAIL midrun_reset_state: got busy=%b done=%b c=%h expected 0 0 0", busy, done, c_flat);
    end
    for (int w = 0; w < 50; w++) begin
      @(posedge clk); #1;
      if (done === 1'b1) early = 1'b1;
    end
    tests++;
    if (early) begin
      fails++;
      $display("FAIL midrun_reset no_done: got a done pulse expected none");
    end
    randomize_tile(255);
    pack_and_load();
    run(1'b0, 37, "after_reset");
    check_c("after_reset");
  endtask

  task automatic run5(input logic m, input int exp_lat, input int bval, input string name);
    int cnt;
    bit seen;
    bit ok;
    for (int r = 0; r < N5; r++)
      for (int c = 0; c < N5; c++) a5[(r*N5+c)*DW +: DW] = DW'(r + c);
    for (int i = 0; i < K5*K5; i++) b5[i*DW +: DW] = DW'(bval);
    @(negedge clk); load5 = 1'b1;
    @(negedge clk); load5 = 1'b0; start5 = 1'b1; mode5 = m;
    @(posedge clk); #1;
    start5 = 1'b0;
    cnt = 0; seen = 1'b0;
    while (!seen && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
      seen = (done5 === 1'b1);
    end
    tests++;
    if (!seen || cnt != exp_lat) begin
      fails++;
      $display("FAIL %s latency: got %0d (seen=%0b) expected %0d", name, cnt, seen, exp_lat);
    end
    ok = 1'b1;
    for (int r = 0; r < M5; r++)
      for (int c = 0; c < M5; c++)
        if (c5[(r*M5+c)*DW +: DW] !== DW'(bval * (4*(r+c) + 4))) ok = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s values: got %h expected c(r,c)=%0d*(4*(r+c)+4)", name, c5, bval);
    end
    @(posedge clk); #1;
    tests++;
    if (done5 !== 1'b0 || busy5 !== 1'b0) begin
      fails++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done5, busy5);
    end
  endtask

  task automatic test_param();
    run5(1'b0, 65, 1, "param_mode0");
    run5(1'b1, 17, 2, "param_mode1");
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_overflow();
    test_mode1();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_start_held();
    test_reset_midrun();
    test_param();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
